// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sequential Booth multiplier.
// FSM state encodings, Booth pair codes and counter width helper.
package multiplicador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIM  = 2'b10
    } state_t;

    // {Q[0], q-1} pair codes
    localparam logic [1:0] BP_NOP0 = 2'b00;
    localparam logic [1:0] BP_ADD  = 2'b01;
    localparam logic [1:0] BP_SUB  = 2'b10;
    localparam logic [1:0] BP_NOP1 = 2'b11;

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/multiplicador_seq_if.sv
// Start/idle/done handshake and operand/result bus of the multiplier.
// master: control unit side; slave: multiplier side.
interface multiplicador_seq_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   multiplicando;
    logic [WIDTH-1:0]   multiplicador;
    logic               sinal;
    logic               start;
    logic [2*WIDTH-1:0] produto;
    logic               idle;
    logic               done;

    modport master (
        output multiplicando, multiplicador, sinal, start,
        input  produto, idle, done
    );

    modport slave (
        input  multiplicando, multiplicador, sinal, start,
        output produto, idle, done
    );
endinterface

// File: rtl/multiplicador_seq_booth_passo.sv
// One radix-2 Booth iteration: add/sub by pair, then arithmetic shift.
// Ports: a_i/q_i/qm1_i/m_i current state; a_o/q_o/qm1_o shifted result.
module booth_passo
    import multiplicador_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH+1:0] a_i,
    input  logic [WIDTH:0]   q_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH+1:0] a_o,
    output logic [WIDTH:0]   q_o,
    output logic             qm1_o
);
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] sum;

    assign m_ext = {m_i[WIDTH], m_i};

    always_comb begin
        sum = a_i;
        unique case ({q_i[0], qm1_i})
            BP_ADD:  sum = a_i + m_ext;
            BP_SUB:  sum = a_i - m_ext;
            default: sum = a_i;
        endcase
    end

    assign a_o   = {sum[WIDTH+1], sum[WIDTH+1:1]};
    assign q_o   = {sum[0], q_i[WIDTH:1]};
    assign qm1_o = q_i[0];

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential signed/unsigned multiplier, radix-2 Booth, WIDTH+1 steps.
// Ports: clk, rst (async high), bus (slave): operands, start, produto, idle, done.
module multiplicador_seq
    import multiplicador_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    multiplicador_seq_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t             state_q;
    logic [WIDTH+1:0]   a_q, a_d;
    logic [WIDTH:0]     q_q, q_d;
    logic [WIDTH:0]     m_q;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] produto_q;
    logic               idle_q;
    logic               done_q;
    logic [2*WIDTH+2:0] full_d;

    booth_passo #(.WIDTH(WIDTH)) u_passo (
        .a_i   (a_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .a_o   (a_d),
        .q_o   (q_d),
        .qm1_o (qm1_d)
    );

    assign full_d = {a_d, q_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            produto_q <= '0;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        // extension bit carries the signed/unsigned mode
                        m_q <= {bus.sinal & bus.multiplicando[WIDTH-1],
                                bus.multiplicando};
                        q_q <= {bus.sinal & bus.multiplicador[WIDTH-1],
                                bus.multiplicador};
                        a_q     <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= CNT_INIT;
                        idle_q  <= 1'b0;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        produto_q <= full_d[2*WIDTH-1:0];
                        done_q    <= 1'b1;
                        state_q   <= ST_FIM;
                    end
                end
                ST_FIM: begin
                    done_q  <= 1'b0;
                    idle_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    idle_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.produto = produto_q;
    assign bus.idle    = idle_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Directed bench for multiplicador_seq at WIDTH=16 and WIDTH=8.
// Checks products, latency, idle/done timing, hold, ignored start, reset.
module tb_multiplicador_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiplicador_seq_if #(.WIDTH(16)) b16 ();
    multiplicador_seq_if #(.WIDTH(8))  b8 ();

    multiplicador_seq #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    multiplicador_seq #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b,
                        input logic s, input int inj, input int rst_at,
                        input logic [31:0] hold, output int lat,
                        output int ilow, output int ndone);
        @(negedge clk);
        b16.multiplicando = a;
        b16.multiplicador = b;
        b16.sinal = s;
        b16.start = 1'b1;
        @(posedge clk);
        #1;
        b16.start = 1'b0;
        b16.multiplicando = ~a;
        b16.multiplicador = ~b;
        b16.sinal = ~s;
        lat = 0;
        ndone = 0;
        ilow = b16.idle ? 0 : 1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (inj != 0 && k == inj + 1) b16.start = 1'b0;
            if (b16.done) begin
                ndone++;
                if (lat == 0) lat = k;
                if (b16.idle) chk("done_with_idle", 1, 0);
            end
            if (k == 5 || k == 16) chk("produto_hold", b16.produto, hold);
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_idle", b16.idle, 1);
                chk("rst_done", b16.done, 0);
                chk("rst_produto", b16.produto, 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (b16.idle) break;
            ilow++;
            if (inj != 0 && k == inj) begin
                b16.start = 1'b1;
                b16.multiplicando = 16'h0003;
                b16.multiplicador = 16'h0003;
            end
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic s, output int lat);
        @(negedge clk);
        b8.multiplicando = a;
        b8.multiplicador = b;
        b8.sinal = s;
        b8.start = 1'b1;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (b8.done && lat == 0) lat = k;
            if (b8.idle) break;
        end
    endtask

    int lat, ilow, nd;

    initial begin
        rst = 1'b1;
        b16.multiplicando = '0;
        b16.multiplicador = '0;
        b16.sinal = 1'b0;
        b16.start = 1'b0;
        b8.multiplicando = '0;
        b8.multiplicador = '0;
        b8.sinal = 1'b0;
        b8.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_idle16", b16.idle, 1);
        chk("reset_done16", b16.done, 0);
        chk("reset_produto16", b16.produto, 0);
        chk("reset_idle8", b8.idle, 1);
        chk("reset_produto8", b8.produto, 0);

        op16(16'hFFFF, 16'hFFFF, 1'b0, 0, 0, 32'h0, lat, ilow, nd);
        chk("u_ffff_ffff", b16.produto, 32'hFFFE0001);
        chk("latency16", lat, 17);
        chk("idle_low16", ilow, 18);
        chk("done_count", nd, 1);

        op16(16'hFFFD, 16'h0005, 1'b1, 0, 0, 32'hFFFE0001, lat, ilow, nd);
        chk("s_m3_x5", b16.produto, 32'hFFFFFFF1);

        op16(16'h8000, 16'h8000, 1'b1, 0, 0, 32'hFFFFFFF1, lat, ilow, nd);
        chk("s_min_min", b16.produto, 32'h40000000);

        op16(16'h7FFF, 16'h8000, 1'b1, 0, 0, 32'h40000000, lat, ilow, nd);
        chk("s_max_min", b16.produto, 32'hC0008000);

        op16(16'h0000, 16'h1234, 1'b1, 0, 0, 32'hC0008000, lat, ilow, nd);
        chk("s_zero", b16.produto, 32'h0);

        op16(16'h0005, 16'h0007, 1'b0, 0, 0, 32'h0, lat, ilow, nd);
        chk("u_5x7", b16.produto, 32'h23);

        op16(16'h0000, 16'h1234, 1'b0, 0, 0, 32'h23, lat, ilow, nd);
        chk("u_zero", b16.produto, 32'h0);

        op16(16'h0100, 16'h0010, 1'b0, 5, 0, 32'h0, lat, ilow, nd);
        chk("inj_result", b16.produto, 32'h1000);
        chk("inj_done_count", nd, 1);
        chk("inj_latency", lat, 17);

        op16(16'h1234, 16'h5678, 1'b0, 0, 8, 32'h1000, lat, ilow, nd);
        @(posedge clk);
        #1;
        chk("post_rst_idle", b16.idle, 1);
        chk("post_rst_produto", b16.produto, 0);

        op16(16'h0007, 16'h0006, 1'b0, 0, 0, 32'h0, lat, ilow, nd);
        chk("u_7x6", b16.produto, 32'd42);
        chk("latency_after_rst", lat, 17);

        op8(8'hFF, 8'h02, 1'b1, lat);
        chk("w8_signed", b8.produto, 16'hFFFE);
        chk("latency8", lat, 9);

        op8(8'hFF, 8'h02, 1'b0, lat);
        chk("w8_unsigned", b8.produto, 16'h01FE);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
